chinx_ifetch: RTL and testbench
===============================

// Module: chinx_ifetch
// PURPOSE
//  Instruction-fetch stage directly downstream of the PC register (chinx_pc).
//  - Consumes the current PC and issues word fetches to instruction memory over a req/gnt + rvalid handshake.
//  - Produces the next PC back into the PC register.
//  - Buffers returned instructions with their PCs in a small in-order queue for decode.
//  - Flushes the queue on a branch/exception redirect.
// PARAMETERS
//  ADDR_WIDTH  `ADDR_WIDTH  PC / memory address width (from defines.vh)
//  INST_WIDTH  32           instruction word width
//  IBUF_DEPTH  2            queue entries; power of 2, >=2
// PORTS
//  clk            in   1           clock
//  rst            in   1           asynchronous reset, active-high
//  pc_i           in   ADDR_WIDTH  current PC from chinx_pc
//  npc_o          out  ADDR_WIDTH  next PC to chinx_pc (combinational)
//  redirect_i     in   1           flush + redirect request
//  redirect_pc_i  in   ADDR_WIDTH  redirect target
//  imem_req_o     out  1           fetch request
//  imem_addr_o    out  ADDR_WIDTH  fetch address, word-aligned
//  imem_gnt_i     in   1           request accepted this cycle
//  imem_rvalid_i  in   1           read data valid; in order, >=1 cycle after gnt
//  imem_rdata_i   in   INST_WIDTH  read data
//  inst_valid_o   out  1           queue head valid to decode
//  inst_o         out  INST_WIDTH  head instruction
//  inst_pc_o      out  ADDR_WIDTH  head PC
//  inst_exc_o     out  1           head carries misaligned-fetch exception
//  inst_ready_i   in   1           decode pops head when valid&&ready
// BEHAVIOUR
//  Reset (async, active-high)
//  - All pointers, occupancy and drop_cnt clear to 0.
//  - imem_req_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, inst_exc_o=0.
//  Queue
//  - Circular table of IBUF_DEPTH entries {pc, inst, exc, filled} with three pointers:
//    - alloc: advances on grant.
//    - fill: advances on an accepted rvalid.
//    - head: advances on pop.
//  - occ = allocated but not yet popped.
//  Issue
//  - imem_req_o = !redirect_i && (occ + drop_cnt < IBUF_DEPTH).
//  - imem_addr_o = {pc_i[AW-1:2], 2'b00}.
//  Next PC
//  - redirect_i:          npc_o = redirect_pc_i.
//  - else req && gnt:     npc_o = pc_i + 4 (wraps modulo 2^AW).
//  - else:                npc_o = pc_i (hold).
//  Return path
//  - rvalid with drop_cnt > 0: data discarded, drop_cnt decrements.
//  - rvalid otherwise: writes the fill entry, and filled=1.
//  - Write at edge T means inst_valid_o is high from T+1, i.e. 1-cycle latency after rvalid.
//  Head output
//  - inst_valid_o = head entry filled. Registered data; no rdata bypass.
//  Flush on redirect_i
//  - Pointers and occ clear; entries are invalidated.
//  - drop_cnt += granted-but-unfilled entries, including a grant in the same cycle (grant still counts).
//  - A pop in the same cycle is discarded.
//  Simultaneous events
//  - Grant, rvalid and pop in one cycle are all legal; occ updates by +grant -pop.
//  Reset mid-operation
//  - rst asserted mid-fetch clears drop_cnt, so the imem side must be reset by the same rst.
//  - An rvalid with no allocated, unfilled entry is ignored; simulation flags it with an assertion.
//  Occupancy bounds
//  - Full: no request is issued; the PC holds.
//  - Empty: inst_valid_o=0.
// CONFIGURATION
//  CHINX_IF_MISALIGN_EN
//  - Defined: when pc_i[1:0] != 0 and no redirect, no imem request is made.
//    - Instead, if a slot is free, one entry is allocated already filled: inst=0, exc=1, pc=pc_i.
//    - npc_o = pc_i (hold). Downstream redirect clears it.
//  - Undefined: pc_i[1:0] ignored; inst_exc_o tied to 0.
// STRUCTURE
//  - chinx_pkg holds: ibuf_entry_t struct {pc, inst, exc, filled}; PC_INC=4; ALIGN_BITS=2.
//  - One sub-module, chinx_ibuf: the pointer-based entry table with alloc/fill/pop/flush.
//  - The top level holds request, next-PC and drop_cnt logic.
// TESTING
//  1. Reset, pc_i=0, gnt always 1, rvalid 1 cycle after gnt, ready=1.
//     -> imem_addr_o 0,4,8; inst_pc_o 0,4,8 in order.
//  2. ready=0 with DEPTH=2.
//     -> after 2 grants imem_req_o=0 and npc_o==pc_i.
//     -> releasing ready resumes issue the next cycle.
//  3. Two grants outstanding, redirect_i with redirect_pc_i=0x100.
//     -> npc_o=0x100; both late rvalids dropped.
//     -> first inst_pc_o after redirect is 0x100.
//  4. redirect_i, gnt and pop in the same cycle.
//     -> drop_cnt includes that grant; no stale instruction reaches decode.
//  5. pc_i=0xFFFF_FFFC, gnt=1.
//     -> npc_o=0x0 (wrap); entry pc 0xFFFF_FFFC.
//  6. With CHINX_IF_MISALIGN_EN: pc_i=0x6.
//     -> no imem_req_o; inst_valid_o=1, inst_exc_o=1, inst_pc_o=0x6.
//     -> without the macro, imem_addr_o=0x4.

Source files
------------

// File: rtl/chinx_pkg.sv
// chinx_pkg: shared types and constants for the chinx fetch stage
package chinx_pkg;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int PC_INC = 4;
  localparam int ALIGN_BITS = 2;
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
    logic          exc;
    logic          filled;
  } ibuf_entry_t;
endpackage

// File: rtl/chinx_ibuf.sv
// chinx_ibuf: in-order fetch queue with alloc/fill/head pointers and flush
module chinx_ibuf
  import chinx_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc,
  input  logic          alloc_exc,
  input  logic [AW-1:0] alloc_pc,
  input  logic          fill,
  input  logic [IW-1:0] fill_inst,
  input  logic          pop,
  input  logic          flush,
  output ibuf_entry_t   head,
  output logic [CW-1:0] occ,
  output logic [CW-1:0] pend
);
  ibuf_entry_t ent [DEPTH];
  logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr;
  assign head = ent[head_ptr];
  // exception entries are born filled and only ever trail real fetches, so fill never reaches them
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alloc_ptr <= '0;
      fill_ptr <= '0;
      head_ptr <= '0;
      occ <= '0;
      pend <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr <= '0;
      head_ptr <= '0;
      occ <= '0;
      pend <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i].filled <= 1'b0;
    end else begin
      if (pop) begin
        ent[head_ptr].filled <= 1'b0;
        head_ptr <= head_ptr + 1'b1;
      end
      if (alloc) begin
        ent[alloc_ptr] <= '{pc: alloc_pc, inst: '0, exc: alloc_exc, filled: alloc_exc};
        alloc_ptr <= alloc_ptr + 1'b1;
      end
      if (fill) begin
        ent[fill_ptr].inst <= fill_inst;
        ent[fill_ptr].filled <= 1'b1;
        fill_ptr <= fill_ptr + 1'b1;
      end
      occ <= occ + CW'(alloc) - CW'(pop);
      pend <= pend + CW'(alloc && !alloc_exc) - CW'(fill);
    end
endmodule

// File: rtl/chinx_ifetch.sv
// chinx_ifetch: fetch stage issuing imem requests, next-PC and redirect drop tracking
// Optional CHINX_IF_MISALIGN_EN turns misaligned PCs into exception entries.
module chinx_ifetch
  import chinx_pkg::*;
#(
  parameter int ADDR_WIDTH = AW,
  parameter int INST_WIDTH = IW,
  parameter int IBUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic [ADDR_WIDTH-1:0] npc_o,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [INST_WIDTH-1:0] imem_rdata_i,
  output logic                  inst_valid_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  inst_exc_o,
  input  logic                  inst_ready_i
);
  localparam int CW = $clog2(IBUF_DEPTH) + 1;
  localparam int DW = CW + 1;
  ibuf_entry_t head;
  logic [CW-1:0] occ, pend;
  logic [DW-1:0] drop_cnt, outstanding;
  logic space, fire, mis, rv_any;
  assign outstanding = drop_cnt + DW'(pend);
  assign space = DW'(occ) + drop_cnt < DW'(IBUF_DEPTH);
`ifdef CHINX_IF_MISALIGN_EN
  assign mis = !redirect_i && pc_i[ALIGN_BITS-1:0] != '0;
  assign inst_exc_o = head.exc;
`else
  logic unused_misalign;
  assign unused_misalign = ^{head.exc, pc_i[ALIGN_BITS-1:0]};
  assign mis = 1'b0;
  assign inst_exc_o = 1'b0;
`endif
  assign imem_req_o = !rst && !redirect_i && !mis && space;
  assign imem_addr_o = {pc_i[ADDR_WIDTH-1:ALIGN_BITS], ALIGN_BITS'(0)};
  // a grant racing a redirect belongs to a request already on the bus and will return data
  assign fire = imem_gnt_i && (imem_req_o || redirect_i);
  assign npc_o = redirect_i ? redirect_pc_i : (imem_req_o && imem_gnt_i) ? pc_i + ADDR_WIDTH'(PC_INC) : pc_i;
  assign rv_any = imem_rvalid_i && outstanding != '0;
  assign inst_valid_o = head.filled;
  assign inst_o = head.inst;
  assign inst_pc_o = head.pc;
  always_ff @(posedge clk or posedge rst)
    if (rst) drop_cnt <= '0;
    else if (redirect_i) drop_cnt <= outstanding + DW'(fire) - DW'(rv_any);
    else drop_cnt <= drop_cnt - DW'(imem_rvalid_i && drop_cnt != '0);
  chinx_ibuf #(.DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk(clk),
    .rst(rst),
    .alloc((fire && !redirect_i) || (mis && space)),
    .alloc_exc(mis),
    .alloc_pc(pc_i),
    .fill(imem_rvalid_i && drop_cnt == '0 && pend != '0),
    .fill_inst(imem_rdata_i),
    .pop(head.filled && inst_ready_i),
    .flush(redirect_i),
    .head(head),
    .occ(occ),
    .pend(pend)
  );
`ifndef SYNTHESIS
  rvalid_expected: assert property (@(posedge clk) disable iff (rst) imem_rvalid_i |-> outstanding != '0);
`endif
endmodule

// File: tb/tb_chinx_ifetch.sv
// tb_chinx_ifetch: scoreboard bench; the bench plays both the PC register and instruction memory
module tb_chinx_ifetch;
  logic clk = 0, rst = 1;
  logic [31:0] pc_i = 0, npc_o, redirect_pc_i = 0, imem_addr_o, imem_rdata_i = 0, inst_o, inst_pc_o;
  logic redirect_i = 0, imem_req_o, imem_gnt_i = 0, imem_rvalid_i = 0, inst_valid_o, inst_exc_o, inst_ready_i = 0;
  typedef struct {logic [31:0] pc; logic [31:0] inst; logic exc;} exp_t;
  exp_t exp[$];
  logic [31:0] mq[$], pop_log[$];
  logic mem_stall = 0;
  logic s_req, s_fire, s_valid, s_exc;
  logic [31:0] s_npc, s_pc, s_addr, s_inst, s_ipc;
  int total = 0, bad = 0;

  chinx_ifetch dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .npc_o(npc_o), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i), .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_exc_o(inst_exc_o), .inst_ready_i(inst_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic tick();
    logic f;
    logic [31:0] a, n;
    exp_t e;
    #2;
    s_req = imem_req_o; s_npc = npc_o; s_pc = pc_i; s_addr = imem_addr_o; s_valid = inst_valid_o;
    s_inst = inst_o; s_ipc = inst_pc_o; s_exc = inst_exc_o;
    f = imem_gnt_i && (imem_req_o || redirect_i);
    s_fire = f; a = imem_addr_o; n = npc_o;
    if (redirect_i) exp.delete();
    else begin
      if (inst_valid_o && inst_ready_i) begin
        total++;
        pop_log.push_back(inst_pc_o);
        if (exp.size() == 0) begin
          bad++;
          $display("FAIL pop_unexpected: got pc=%h inst=%h, want no instruction", inst_pc_o, inst_o);
        end else begin
          e = exp.pop_front();
          if ({inst_pc_o, inst_o, inst_exc_o} !== {e.pc, e.inst, e.exc}) begin
            bad++;
            $display("FAIL pop_data: got pc=%h inst=%h exc=%b, want pc=%h inst=%h exc=%b",
                     inst_pc_o, inst_o, inst_exc_o, e.pc, e.inst, e.exc);
          end
        end
      end
      if (f) exp.push_back('{pc: pc_i, inst: inst_of(a), exc: 1'b0});
    end
    if (f) mq.push_back(a);
    @(posedge clk);
    #1;
    pc_i = rst ? 32'h0 : n;
    if (mq.size() != 0 && !mem_stall) begin
      imem_rvalid_i = 1;
      imem_rdata_i = inst_of(mq.pop_front());
    end else begin
      imem_rvalid_i = 0;
      imem_rdata_i = 0;
    end
  endtask

  task automatic first_pop(input logic [31:0] want, input string name);
    int n0 = pop_log.size();
    for (int i = 0; i < 20 && pop_log.size() == n0; i++) tick();
    total++;
    if (pop_log.size() == n0) begin
      bad++;
      $display("FAIL %s: got no pop in 20 cycles, want pc=%h", name, want);
    end else if (pop_log[n0] !== want) begin
      bad++;
      $display("FAIL %s: got pc=%h, want %h", name, pop_log[n0], want);
    end
  endtask

  task automatic drain(input string name);
    imem_gnt_i = 0; inst_ready_i = 1; mem_stall = 0;
    for (int i = 0; i < 30 && (exp.size() != 0 || mq.size() != 0); i++) tick();
    tick();
    total++;
    if (exp.size() != 0 || s_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain: got left=%0d valid=%b, want left=0 valid=0", name, exp.size(), s_valid);
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    total += 5;
    if (s_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b, want 0", s_req); end
    if (s_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, want 0", s_valid); end
    if (s_inst !== 32'h0) begin bad++; $display("FAIL rst_inst: got %h, want 0", s_inst); end
    if (s_ipc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h, want 0", s_ipc); end
    if (s_exc !== 1'b0) begin bad++; $display("FAIL rst_exc: got %b, want 0", s_exc); end
    rst = 0;
  endtask

  task automatic test_basic();
    logic [31:0] addrs[$];
    logic [31:0] want;
    imem_gnt_i = 1; inst_ready_i = 1;
    for (int i = 0; i < 10 && addrs.size() < 3; i++) begin
      tick();
      if (s_fire) addrs.push_back(s_addr);
    end
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < 3; i++) begin
      want = 32'(4 * i);
      total += 2;
      if (i >= addrs.size() || addrs[i] !== want) begin
        bad++; $display("FAIL basic_addr%0d: got %h, want %h", i, i < addrs.size() ? addrs[i] : 32'hx, want);
      end
      if (i >= pop_log.size() || pop_log[i] !== want) begin
        bad++; $display("FAIL basic_pc%0d: got %h, want %h", i, i < pop_log.size() ? pop_log[i] : 32'hx, want);
      end
    end
  endtask

  task automatic test_backpressure();
    inst_ready_i = 0;
    for (int i = 0; i < 5; i++) tick();
    total += 2;
    if (s_req !== 1'b0) begin bad++; $display("FAIL full_req: got %b, want 0", s_req); end
    if (s_npc !== s_pc) begin bad++; $display("FAIL full_hold: got npc=%h, want %h", s_npc, s_pc); end
    inst_ready_i = 1;
    tick();
    tick();
    total += 2;
    if (s_req !== 1'b1) begin bad++; $display("FAIL resume_req: got %b, want 1", s_req); end
    if (s_npc !== s_pc + 32'd4) begin bad++; $display("FAIL resume_npc: got %h, want %h", s_npc, s_pc + 32'd4); end
    drain("bp");
  endtask

  task automatic test_redirect();
    int fires = 0;
    mem_stall = 1; imem_gnt_i = 1;
    for (int i = 0; i < 2; i++) begin tick(); fires += int'(s_fire); end
    total++;
    if (fires != 2) begin bad++; $display("FAIL redir_setup: got %0d grants, want 2", fires); end
    imem_gnt_i = 0; redirect_i = 1; redirect_pc_i = 32'h100;
    tick();
    total++;
    if (s_npc !== 32'h100) begin bad++; $display("FAIL redir_npc: got %h, want 00000100", s_npc); end
    redirect_i = 0; mem_stall = 0; imem_gnt_i = 1;
    first_pop(32'h100, "redir_first");
    drain("redir");
  endtask

  task automatic test_redirect_gnt_pop();
    imem_gnt_i = 1; inst_ready_i = 0;
    for (int i = 0; i < 4; i++) tick();
    redirect_i = 1; redirect_pc_i = 32'h200; inst_ready_i = 1;
    tick();
    total++;
    if ({s_valid, s_fire} !== 2'b11) begin bad++; $display("FAIL rgp_setup: got valid=%b grant=%b, want 1 1", s_valid, s_fire); end
    redirect_i = 0;
    first_pop(32'h200, "rgp_first");
    drain("rgp");
  endtask

  task automatic test_wrap();
    redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 0; imem_gnt_i = 1;
    tick();
    total += 2;
    if (!s_fire || s_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr: got grant=%b addr=%h, want 1 fffffffc", s_fire, s_addr); end
    if (s_npc !== 32'h0) begin bad++; $display("FAIL wrap_npc: got %h, want 0", s_npc); end
    first_pop(32'hFFFF_FFFC, "wrap_first");
    drain("wrap");
  endtask

  task automatic test_misalign();
`ifdef CHINX_IF_MISALIGN_EN
    inst_ready_i = 0; imem_gnt_i = 0; redirect_i = 1; redirect_pc_i = 32'h6;
    tick();
    redirect_i = 0; imem_gnt_i = 1;
    tick();
    total++;
    if (s_req !== 1'b0) begin bad++; $display("FAIL mis_req: got %b, want 0", s_req); end
    tick();
    total++;
    if ({s_valid, s_exc, s_ipc, s_inst} !== {1'b1, 1'b1, 32'h6, 32'h0})
      begin bad++; $display("FAIL mis_entry: got valid=%b exc=%b pc=%h inst=%h, want 1 1 6 0", s_valid, s_exc, s_ipc, s_inst); end
    imem_gnt_i = 0; redirect_i = 1; redirect_pc_i = 32'h0;
    tick();
    redirect_i = 0;
`else
    redirect_i = 1; redirect_pc_i = 32'h6;
    tick();
    redirect_i = 0; imem_gnt_i = 1;
    tick();
    total++;
    if (!s_fire || s_addr !== 32'h4) begin bad++; $display("FAIL mis_addr: got grant=%b addr=%h, want 1 4", s_fire, s_addr); end
    first_pop(32'h6, "mis_first");
`endif
    drain("mis");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_redirect_gnt_pop();
    test_wrap();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
